// File: rtl/mnacidpro_sequencer.sv
// Purpose : Valve/pump sequencer for the nucleic-acid prep chip:
//           IDLE -> LOAD -> LYSE -> WASH (-> WASH again) -> ELUTE -> COLLECT -> DONE.
// Latency : all outputs registered; start sampled at edge k gives SETTLE/busy from cycle k+1.
// Backpressure: none; abort in any busy state returns to IDLE on the next edge.
// Ports   : clk, rst_n (async active-low), start, abort  -> inputs
//           valve[10:0], pump[2:0] (1 = closed), busy, done, aborted -> outputs
// Option  : define MNACIDPRO_SEQ_WASH2_EN to run a second WASH pass before ELUTE.
//           Zero-valued count parameters are treated as 1.
module mnacidpro_sequencer #(
  parameter int PHASE_CYC       = 4,
  parameter int SETTLE_CYC      = 2,
  parameter int LOAD_STROKES    = 8,
  parameter int LYSE_STROKES    = 4,
  parameter int WASH_STROKES    = 6,
  parameter int ELUTE_STROKES   = 3,
  parameter int COLLECT_STROKES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [10:0] valve,
  output logic [2:0]  pump,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  localparam int PHASE_N   = (PHASE_CYC       < 1) ? 1 : PHASE_CYC;
  localparam int SETTLE_N  = (SETTLE_CYC      < 1) ? 1 : SETTLE_CYC;
  localparam int LOAD_N    = (LOAD_STROKES    < 1) ? 1 : LOAD_STROKES;
  localparam int LYSE_N    = (LYSE_STROKES    < 1) ? 1 : LYSE_STROKES;
  localparam int WASH_N    = (WASH_STROKES    < 1) ? 1 : WASH_STROKES;
  localparam int ELUTE_N   = (ELUTE_STROKES   < 1) ? 1 : ELUTE_STROKES;
  localparam int COLLECT_N = (COLLECT_STROKES < 1) ? 1 : COLLECT_STROKES;
  localparam int MAX_A     = (LOAD_N  > LYSE_N)    ? LOAD_N  : LYSE_N;
  localparam int MAX_B     = (WASH_N  > ELUTE_N)   ? WASH_N  : ELUTE_N;
  localparam int MAX_C     = (MAX_A   > MAX_B)     ? MAX_A   : MAX_B;
  localparam int MAX_N     = (MAX_C   > COLLECT_N) ? MAX_C   : COLLECT_N;

  // Counters only ever reach N-1; the +1 keeps a width of at least one bit.
  localparam int PW  = $clog2(PHASE_N + 1);
  localparam int SW  = $clog2(SETTLE_N + 1);
  localparam int STW = $clog2(MAX_N + 1);

  localparam logic [10:0] ALL_CLOSED = 11'h7FF;
  localparam logic [2:0]  PUMP_STOP  = 3'b111;
  localparam logic [2:0]  PUMP_PH0   = 3'b011;

  typedef enum logic [3:0] {
    S_IDLE, S_SETTLE, S_LOAD, S_LYSE, S_WASH, S_ELUTE, S_COLLECT, S_DONE
  } state_t;

  state_t           state;
  state_t           nxt_stage;   // stage entered when the current SETTLE ends
  logic [PW-1:0]    phase_cnt;
  logic [1:0]       phase_idx;
  logic [STW-1:0]   stroke_cnt;
  logic [SW-1:0]    settle_cnt;
`ifdef MNACIDPRO_SEQ_WASH2_EN
  logic             wash_second; // set while the second WASH pass is pending/running
`endif

  // Bits that are opened (driven 0) in each pumping stage.
  function automatic logic [10:0] open_mask(input state_t s);
    case (s)
      S_LOAD:    open_mask = 11'b000_1110_0000;  // horiz, waste, bead
      S_LYSE:    open_mask = 11'b001_0001_0001;  // lysis, vertical, loop_exit
      S_WASH:    open_mask = 11'b010_0100_0010;  // wash, waste, bead_trap
      S_ELUTE:   open_mask = 11'b010_0000_1100;  // elute, dead_end, bead_trap
      S_COLLECT: open_mask = 11'b101_0000_0000;  // loop_exit, collect
      default:   open_mask = 11'b000_0000_0000;
    endcase
  endfunction

  function automatic logic [2:0] pump_code(input logic [1:0] idx);
    case (idx)
      2'd0:    pump_code = 3'b011;
      2'd1:    pump_code = 3'b101;
      default: pump_code = 3'b110;
    endcase
  endfunction

  function automatic logic [STW-1:0] last_stroke(input state_t s);
    case (s)
      S_LOAD:  last_stroke = STW'(LOAD_N - 1);
      S_LYSE:  last_stroke = STW'(LYSE_N - 1);
      S_WASH:  last_stroke = STW'(WASH_N - 1);
      S_ELUTE: last_stroke = STW'(ELUTE_N - 1);
      default: last_stroke = STW'(COLLECT_N - 1);
    endcase
  endfunction

  function automatic state_t successor(input state_t s);
    case (s)
      S_LOAD:  successor = S_LYSE;
      S_LYSE:  successor = S_WASH;
      S_WASH:  successor = S_ELUTE;
      S_ELUTE: successor = S_COLLECT;
      default: successor = S_DONE;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      nxt_stage  <= S_LOAD;
      phase_cnt  <= '0;
      phase_idx  <= '0;
      stroke_cnt <= '0;
      settle_cnt <= '0;
      valve      <= ALL_CLOSED;
      pump       <= PUMP_STOP;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
`ifdef MNACIDPRO_SEQ_WASH2_EN
      wash_second <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_SETTLE;
            nxt_stage  <= S_LOAD;
            settle_cnt <= '0;
            busy       <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          if (abort) begin
            // Abort wins over both stage completion and settle expiry.
            state      <= S_IDLE;
            phase_cnt  <= '0;
            phase_idx  <= '0;
            stroke_cnt <= '0;
            settle_cnt <= '0;
            valve      <= ALL_CLOSED;
            pump       <= PUMP_STOP;
            busy       <= 1'b0;
            aborted    <= 1'b1;
`ifdef MNACIDPRO_SEQ_WASH2_EN
            wash_second <= 1'b0;
`endif
          end else if (state == S_SETTLE) begin
            if (settle_cnt == SW'(SETTLE_N - 1)) begin
              state      <= nxt_stage;
              settle_cnt <= '0;
              phase_cnt  <= '0;
              phase_idx  <= '0;
              stroke_cnt <= '0;
              valve      <= ~open_mask(nxt_stage);
              pump       <= PUMP_PH0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end else if (phase_cnt != PW'(PHASE_N - 1)) begin
            phase_cnt <= phase_cnt + 1'b1;
          end else begin
            phase_cnt <= '0;
            if (phase_idx != 2'd2) begin
              phase_idx <= phase_idx + 1'b1;
              pump      <= pump_code(phase_idx + 2'd1);
            end else if (stroke_cnt != last_stroke(state)) begin
              phase_idx  <= '0;
              stroke_cnt <= stroke_cnt + 1'b1;
              pump       <= PUMP_PH0;
            end else begin
              // Last phase of last stroke: leave the stage.
              phase_idx  <= '0;
              stroke_cnt <= '0;
              valve      <= ALL_CLOSED;
              pump       <= PUMP_STOP;
              if (state == S_COLLECT) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state      <= S_SETTLE;
                settle_cnt <= '0;
`ifdef MNACIDPRO_SEQ_WASH2_EN
                if (state == S_WASH && !wash_second) begin
                  wash_second <= 1'b1;
                  nxt_stage   <= S_WASH;
                end else begin
                  wash_second <= 1'b0;
                  nxt_stage   <= successor(state);
                end
`else
                nxt_stage <= successor(state);
`endif
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mnacidpro_sequencer.md
MNACIDPRO_SEQUENCER -- requirements
Module: mnacidpro_sequencer

Interface
REQ-001 SHALL have parameter PHASE_CYC, default 4: clock cycles per pump phase.
REQ-002 SHALL have parameter SETTLE_CYC, default 2: all-closed settle cycles before each stage.
REQ-003 SHALL have parameter LOAD_STROKES, default 8: pump strokes in LOAD.
REQ-004 SHALL have parameter LYSE_STROKES, default 4: pump strokes in LYSE.
REQ-005 SHALL have parameter WASH_STROKES, default 6: pump strokes per WASH pass.
REQ-006 SHALL have parameter ELUTE_STROKES, default 3: pump strokes in ELUTE.
REQ-007 SHALL have parameter COLLECT_STROKES, default 2: pump strokes in COLLECT.
REQ-008 SHALL have port clk  input  1  sole clock, rising edge.
REQ-009 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-010 SHALL have port start  input  1  run request, sampled in IDLE only.
REQ-011 SHALL have port abort  input  1  stop request, any state.
REQ-012 SHALL have port valve  output  11  chip control lines; 1 = valve closed; bit order 0 lysis, 1 wash, 2 elute, 3 dead_end, 4 vertical, 5 horiz, 6 waste, 7 bead, 8 loop_exit, 9 bead_trap, 10 collect.
REQ-013 SHALL have port pump  output  3  peristaltic pump valve lines, 1 = closed.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE and DONE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal completion.
REQ-016 SHALL have port aborted  output  1  one-cycle pulse when an abort is taken.

Function
REQ-017 SHALL sequence IDLE -> LOAD -> LYSE -> WASH -> ELUTE -> COLLECT -> DONE -> IDLE, with a SETTLE interval of SETTLE_CYC cycles before every stage.
REQ-018 SHALL register all outputs; start sampled high in IDLE at edge k gives busy=1 and SETTLE from cycle k+1.
REQ-019 SHALL drive valve=all ones and pump=3'b111 in IDLE, SETTLE and DONE.
REQ-020 SHALL open (drive 0) only: LOAD bits 5,6,7; LYSE bits 0,4,8; WASH bits 1,6,9; ELUTE bits 2,3,9; COLLECT bits 8,10; all other bits 1.
REQ-021 SHALL, in each pumping stage, cycle pump 3'b011 -> 3'b101 -> 3'b110, each held PHASE_CYC cycles; one stroke = 3*PHASE_CYC cycles.
REQ-022 SHALL leave a stage after exactly N strokes (N = its parameter; N=0 treated as 1), pump restarting at 3'b011 in each new stage.
REQ-023 SHALL size phase, stroke and settle counters for the parameter values; no counter wraps.
REQ-024 SHALL hold DONE one cycle with done=1, then return to IDLE.
REQ-025 SHALL ignore start while not in IDLE.
REQ-026 SHALL on abort in any busy state go to IDLE next cycle: valves all closed, pump 3'b111, aborted=1 one cycle, counters cleared.
REQ-027 SHALL give abort priority over stage completion and over start in the same cycle; no done pulse then.
REQ-028 SHALL ignore abort in IDLE and DONE (no aborted pulse, DONE still completes).

Reset
REQ-029 SHALL on rst_n low, asynchronously: state IDLE, valve=11'h7FF, pump=3'b111, busy=0, done=0, aborted=0, all counters 0.
REQ-030 SHALL on reset mid-run discard progress; after release wait in IDLE for a new start.

Configuration
REQ-031 SHALL, with MNACIDPRO_SEQ_WASH2_EN defined, run a second WASH pass (own SETTLE, WASH_STROKES strokes, same valve pattern) between WASH and ELUTE.
REQ-032 SHALL, without MNACIDPRO_SEQ_WASH2_EN, run a single WASH pass and contain no second-pass logic.

Verification
REQ-033 SHALL cover: defaults, start pulse at edge 0 -> LOAD pattern (valve=11'h71F) cycles 3..98, done=1 exactly at cycle 287, busy low at 287.
REQ-034 SHALL cover: defaults, observe pump in LOAD -> 011,101,110 each 4 cycles, repeated 8 times, 3'b111 during every SETTLE.
REQ-035 SHALL cover: abort at cycle 160 (WASH) -> cycle 161 valve=11'h7FF, pump=3'b111, aborted=1 one cycle, busy=0, no done.
REQ-036 SHALL cover: start re-pulsed at cycle 50 and abort in IDLE -> no effect; done still at 287, aborted never high.
REQ-037 SHALL cover: rst_n low at cycle 120 asynchronously -> outputs at reset values before next edge; new start after release restarts timing from LOAD.
REQ-038 SHALL cover: MNACIDPRO_SEQ_WASH2_EN defined, defaults -> two WASH passes of 72 cycles each, done at cycle 361.
